bus_xfer_ctrl: RTL and testbench
================================

Name: bus_xfer_ctrl

Overview:
- Sequences register-to-register moves over the shared tri-state databus that connects a bank of NREG bus registers. Each register has its own output-enable and load strobe.
- Arbitrates among NREQ requesters with a round-robin policy. Each requester asks for one move of the form "copy register src into register dst".
- Drives one-hot oe and load strobes with a settle cycle and a turnaround cycle, so that two drivers never share the bus.
- Sits between the bus-register bank and the sequencing logic or test stimulus.

Parameters:
- NREG, 4, number of registers on the databus (2..16).
- NREQ, 2, number of requesters (1..8).
- SELW, $clog2(NREG), width of a register index (derived, do not override).

Ports:
- clk  input  1  system clock, rising-edge active
- reset  input  1  asynchronous, active-low reset
- req  input  NREQ  per-requester transfer request, level; held until the matching done
- src  input  NREQ*SELW  packed source index per requester; slice i belongs to requester i
- dst  input  NREQ*SELW  packed destination index per requester
- grant  output  NREQ  one-hot, 1-cycle pulse: request accepted and operands latched
- done  output  NREQ  one-hot, 1-cycle pulse: transfer finished
- err  output  1  valid with done; 1 means the request was rejected and no transfer occurred
- oe  output  NREG  one-hot or zero output enables to the bus registers
- load  output  NREG  one-hot or zero load strobes to the bus registers
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset (reset==0) is asynchronous:
  - state=IDLE; rr_ptr=0.
  - grant, done, err, oe, load and busy are all 0.
- All outputs are registered and decoded from the state and the latched operands, so they are glitch-free.
- FSM states:
  - IDLE: wait for a request.
  - DRIVE: oe[src_q]=1 so the bus settles; load=0.
  - LOAD: oe[src_q]=1 and load[dst_q]=1. The destination register captures on the rising edge that ends LOAD.
  - TURN: oe=0 and load=0; done[id_q]=1; err=err_q. Then go to IDLE.
- Arbitration in IDLE when any req is high:
  - Search requesters starting at rr_ptr, wrapping modulo NREQ; pick the first with req high.
  - Latch id_q, src_q and dst_q; pulse grant[id] for 1 cycle.
  - Set rr_ptr=(id+1) mod NREQ.
- Next state after a grant:
  - Valid request: DRIVE.
  - Request with src==dst, src>=NREG or dst>=NREG: set err_q=1 and go straight to TURN. No oe or load is ever asserted for a rejected request.
- Timing:
  - A legal transfer takes 4 cycles: IDLE(grant), DRIVE, LOAD, TURN(done).
  - A rejected request takes 2 cycles.
  - The earliest next grant is in the cycle after TURN, so there is at least one idle-bus cycle between drivers.
- req is sampled only in IDLE. Dropping or changing req, src or dst mid-transfer does not alter the transfer in progress.
- A requester still holding req after its done is eligible again. Round-robin gives the other requesters priority first.
- Invariants the bench checks every cycle:
  - $onehot0(oe) and $onehot0(load).
  - load!=0 implies oe!=0.
  - oe and load never have the same bit set.
  - grant and done never both high in the same cycle.
- Reset asserted mid-transfer:
  - oe and load drop to 0 immediately (asynchronously); no done is issued.
  - The requester must re-request after reset is released.

Decomposition:
- Package bus_xfer_pkg holds:
  - the typedef enum logic [1:0] for the FSM states {IDLE, DRIVE, LOAD, TURN};
  - constants XFER_CYCLES=4 and REJECT_CYCLES=2.
- One sub-module: rr_arbiter (NREQ).
  - Inputs: req, rr_ptr.
  - Outputs: one-hot gnt, encoded id, any.
  - Purely combinational; the pointer register stays in bus_xfer_ctrl.

Test Plan:
- Single transfer (NREG=4, NREQ=2): regs preloaded 0x1111, 0x2222, 0x3333, 0x4444; req0 with src=1, dst=3.
  -> grant[0] in cycle 0; oe=0010 in cycles 1–2; load=1000 in cycle 2; done[0] in cycle 3; err=0; reg3 reads 0x2222.
- Simultaneous requests: req0 (0->2) and req1 (3->0) both asserted and held.
  -> req0 is granted first (rr_ptr=0), req1 is granted 4 cycles later.
  -> Final values: reg2=0x1111, reg0=0x4444.
- Round-robin fairness: both requesters hold req continuously for 8 transfers.
  -> Grants alternate 0,1,0,1,…; neither requester is starved.
- Illegal request: src=2, dst=2, then src=2, dst=5 with NREG=5.
  -> Each gets grant followed by done one cycle later with err=1; oe and load stay 0; register contents unchanged.
- Reset mid-operation: assert reset during the LOAD cycle of a 0->1 transfer.
  -> oe and load go to 0 within the same cycle; no done; reg1 keeps its reset value 0.
  -> After release, a new req is granted by requester 0 (rr_ptr=0).
- Invariant sweep: 1000 random req/src/dst cycles.
  -> No assertion failures (one-hot checks, no load without oe, no X on databus during LOAD).
  -> Every grant is matched by exactly one done.

Source files
------------

// File: rtl/bus_xfer_ctrl_pkg.sv
// rtl/bus_xfer_ctrl_pkg.sv - shared types and timing constants for the databus transfer sequencer
package bus_xfer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        LOAD  = 2'd2,
        TURN  = 2'd3
    } xfer_state_t;

    // Grant-to-done span, counting both end cycles
    localparam int XFER_CYCLES   = 4;
    localparam int REJECT_CYCLES = 2;

endpackage

// File: rtl/bus_xfer_ctrl_if.sv
// rtl/bus_xfer_ctrl_if.sv - requester and bus-register strobe bundle for bus_xfer_ctrl
interface bus_xfer_ctrl_if #(
    parameter int NREG = 4,
    parameter int NREQ = 2
);
    localparam int SELW = $clog2(NREG);

    logic [NREQ-1:0]      req;
    logic [NREQ*SELW-1:0] src;
    logic [NREQ*SELW-1:0] dst;
    logic [NREQ-1:0]      grant;
    logic [NREQ-1:0]      done;
    logic                 err;
    logic [NREG-1:0]      oe;
    logic [NREG-1:0]      load;
    logic                 busy;

    modport master (
        output req, src, dst,
        input  grant, done, err, oe, load, busy
    );

    modport slave (
        input  req, src, dst,
        output grant, done, err, oe, load, busy
    );

endinterface

// File: rtl/bus_xfer_ctrl_rr_arbiter.sv
// rtl/bus_xfer_ctrl_rr_arbiter.sv - combinational round-robin pick starting at a supplied pointer
module rr_arbiter #(
    parameter  int NREQ = 2,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_rr_ptr,
    output logic [NREQ-1:0] o_gnt,
    output logic [IDW-1:0]  o_id,
    output logic            o_any
);

    always_comb begin
        o_gnt = '0;
        o_id  = '0;
        o_any = 1'b0;
        // k is the distance from the pointer; the first hit wins
        for (int k = 0; k < NREQ; k++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!o_any && (j == (int'(i_rr_ptr) + k) % NREQ) && i_req[j]) begin
                    o_any    = 1'b1;
                    o_gnt[j] = 1'b1;
                    o_id     = IDW'(j);
                end
            end
        end
    end

endmodule

// File: rtl/bus_xfer_ctrl.sv
// rtl/bus_xfer_ctrl.sv - round-robin register-to-register databus transfer sequencer
module bus_xfer_ctrl
    import bus_xfer_pkg::*;
#(
    parameter  int NREG = 4,
    parameter  int NREQ = 2,
    localparam int SELW = $clog2(NREG),
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic           clk,
    input  logic           reset,
    bus_xfer_ctrl_if.slave bus
);

    localparam logic [NREG-1:0] REG_ONE = NREG'(1);
    localparam logic [NREQ-1:0] REQ_ONE = NREQ'(1);

    xfer_state_t     r_state;
    xfer_state_t     w_state_nxt;
    logic [IDW-1:0]  r_rr_ptr;
    logic [IDW-1:0]  r_id;
    logic [SELW-1:0] r_src;
    logic [SELW-1:0] r_dst;
    logic            r_err;

    logic [NREQ-1:0] r_grant;
    logic [NREQ-1:0] r_done;
    logic            r_err_o;
    logic [NREG-1:0] r_oe;
    logic [NREG-1:0] r_load;
    logic            r_busy;

    logic [NREQ-1:0] w_arb_gnt;
    logic [IDW-1:0]  w_arb_id;
    logic            w_arb_any;
    logic [SELW-1:0] w_req_src;
    logic [SELW-1:0] w_req_dst;
    logic            w_req_bad;
    logic            w_accept;

    logic [NREQ-1:0] w_grant_nxt;
    logic [NREQ-1:0] w_done_nxt;
    logic            w_err_nxt;
    logic [NREG-1:0] w_oe_nxt;
    logic [NREG-1:0] w_load_nxt;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .i_req    (bus.req),
        .i_rr_ptr (r_rr_ptr),
        .o_gnt    (w_arb_gnt),
        .o_id     (w_arb_id),
        .o_any    (w_arb_any)
    );

    always_comb begin
        w_req_src = '0;
        w_req_dst = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (w_arb_gnt[j]) begin
                w_req_src = bus.src[j*SELW +: SELW];
                w_req_dst = bus.dst[j*SELW +: SELW];
            end
        end
    end

    assign w_req_bad = (w_req_src == w_req_dst) ||
                       (int'(w_req_src) >= NREG) ||
                       (int'(w_req_dst) >= NREG);
    assign w_accept  = (r_state == IDLE) && w_arb_any;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Strobes are computed one cycle ahead and registered, so every
    // visible output is a clean flop decode of the previous state
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = '0;
        w_done_nxt  = '0;
        w_err_nxt   = 1'b0;
        w_oe_nxt    = '0;
        w_load_nxt  = '0;
        case (r_state)
            IDLE: begin
                if (w_arb_any) begin
                    w_grant_nxt = w_arb_gnt;
                    w_state_nxt = w_req_bad ? TURN : DRIVE;
                end
            end
            DRIVE: begin
                w_oe_nxt    = REG_ONE << r_src;
                w_state_nxt = LOAD;
            end
            LOAD: begin
                w_oe_nxt    = REG_ONE << r_src;
                w_load_nxt  = REG_ONE << r_dst;
                w_state_nxt = TURN;
            end
            TURN: begin
                w_done_nxt  = REQ_ONE << r_id;
                w_err_nxt   = r_err;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr_ptr <= '0;
            r_id     <= '0;
            r_src    <= '0;
            r_dst    <= '0;
            r_err    <= 1'b0;
            r_grant  <= '0;
            r_done   <= '0;
            r_err_o  <= 1'b0;
            r_oe     <= '0;
            r_load   <= '0;
            r_busy   <= 1'b0;
        end else begin
            r_grant <= w_grant_nxt;
            r_done  <= w_done_nxt;
            r_err_o <= w_err_nxt;
            r_oe    <= w_oe_nxt;
            r_load  <= w_load_nxt;
            r_busy  <= (r_state != IDLE);
            if (w_accept) begin
                r_id     <= w_arb_id;
                r_src    <= w_req_src;
                r_dst    <= w_req_dst;
                r_err    <= w_req_bad;
                r_rr_ptr <= IDW'((int'(w_arb_id) + 1) % NREQ);
            end
        end
    end

    assign bus.grant = r_grant;
    assign bus.done  = r_done;
    assign bus.err   = r_err_o;
    assign bus.oe    = r_oe;
    assign bus.load  = r_load;
    assign bus.busy  = r_busy;

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// tb/tb_bus_xfer_ctrl.sv - directed and randomised self-checking bench for bus_xfer_ctrl
module tb_bus_xfer_ctrl;
    import bus_xfer_pkg::*;

    localparam int NREG = 5;
    localparam int NREQ = 2;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    logic [15:0] bank    [NREG];
    logic [15:0] pre_val [NREG];
    logic        pre_en;
    logic [15:0] dbus;

    int         m_ptr, m_id, m_age, m_lat, n_grant, n_done;
    logic       m_act, m_err;
    logic [2:0] m_src, m_dst;
    logic [31:0] e_grant, e_oe, e_load, e_done;

    bus_xfer_ctrl_if #(.NREG(NREG), .NREQ(NREQ)) bif ();

    bus_xfer_ctrl #(.NREG(NREG), .NREQ(NREQ)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        dbus = 'x;
        if (bif.oe != '0) begin
            dbus = '0;
            for (int i = 0; i < NREG; i++) if (bif.oe[i]) dbus = dbus | bank[i];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            if (pre_en)           bank[i] <= pre_val[i];
            else if (bif.load[i]) bank[i] <= dbus;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [15:0] v0, v1, v2, v3, v4);
        pre_val[0] = v0; pre_val[1] = v1; pre_val[2] = v2;
        pre_val[3] = v3; pre_val[4] = v4;
        pre_en = 1'b1;
        tick();
        pre_en = 1'b0;
    endtask

    function automatic logic [2:0] sel(input logic [5:0] v, input int i);
        return (i != 0) ? v[5:3] : v[2:0];
    endfunction

    always @(negedge clk) begin
        check("inv_oe_onehot0",   32'($onehot0(bif.oe)), 1);
        check("inv_load_onehot0", 32'($onehot0(bif.load)), 1);
        check("inv_load_needs_oe", 32'((bif.load != '0) && (bif.oe == '0)), 0);
        check("inv_oe_load_overlap", 32'(bif.oe & bif.load), 0);
        check("inv_grant_done", 32'((bif.grant != '0) && (bif.done != '0)), 0);
        if (bif.load != '0) check("inv_dbus_known", 32'($isunknown(dbus)), 0);
    end

    initial begin
        n_checks = 0; n_errors = 0;
        pre_en = 1'b0;
        bif.req = '0; bif.src = '0; bif.dst = '0;
        reset = 1'b1;
        #1 reset = 1'b0;
        tick(); tick();
        check("rst_grant", 32'(bif.grant), 0);
        check("rst_done",  32'(bif.done), 0);
        check("rst_err",   32'(bif.err), 0);
        check("rst_oe",    32'(bif.oe), 0);
        check("rst_load",  32'(bif.load), 0);
        check("rst_busy",  32'(bif.busy), 0);
        reset = 1'b1;
        preload(16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555);

        // single legal move 1 -> 3
        bif.src = {3'd0, 3'd1}; bif.dst = {3'd0, 3'd3}; bif.req = 2'b01;
        tick();
        check("t1_grant", 32'(bif.grant), 'h1);
        check("t1_c0_oe", 32'(bif.oe), 0);
        check("t1_c0_busy", 32'(bif.busy), 0);
        tick();
        check("t1_c1_oe", 32'(bif.oe), 'h2);
        check("t1_c1_load", 32'(bif.load), 0);
        check("t1_c1_busy", 32'(bif.busy), 1);
        tick();
        check("t1_c2_oe", 32'(bif.oe), 'h2);
        check("t1_c2_load", 32'(bif.load), 'h8);
        tick();
        check("t1_done", 32'(bif.done), 'h1);
        check("t1_err", 32'(bif.err), 0);
        check("t1_c3_oe", 32'(bif.oe), 0);
        bif.req = 2'b00;
        tick();
        check("t1_reg3", 32'(bank[3]), 'h2222);
        check("t1_idle_grant", 32'(bif.grant), 0);
        check("t1_idle_busy", 32'(bif.busy), 0);

        // simultaneous requests then round-robin fairness over 8 moves
        reset = 1'b0; tick(); reset = 1'b1;
        preload(16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555);
        bif.src = {3'd3, 3'd0}; bif.dst = {3'd0, 3'd2}; bif.req = 2'b11;
        tick();
        for (int t = 0; t < 8; t++) begin
            check("rr_grant", 32'(bif.grant), (t % 2 == 0) ? 'h1 : 'h2);
            tick();
            check("rr_oe", 32'(bif.oe), (t % 2 == 0) ? 'h1 : 'h8);
            tick();
            check("rr_load", 32'(bif.load), (t % 2 == 0) ? 'h4 : 'h1);
            tick();
            check("rr_done", 32'(bif.done), (t % 2 == 0) ? 'h1 : 'h2);
            if (t == 1) begin
                check("rr_reg2", 32'(bank[2]), 'h1111);
                check("rr_reg0", 32'(bank[0]), 'h4444);
            end
            if (t == 7) bif.req = 2'b00;
            tick();
        end
        check("rr_end_grant", 32'(bif.grant), 0);
        check("rr_end_busy", 32'(bif.busy), 0);

        // rejected requests: src==dst, dst out of range, src out of range
        preload(16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555);
        bif.src = {3'd0, 3'd2}; bif.dst = {3'd0, 3'd2}; bif.req = 2'b01;
        tick();
        check("bad_eq_grant", 32'(bif.grant), 'h1);
        check("bad_eq_err_early", 32'(bif.err), 0);
        tick();
        check("bad_eq_done", 32'(bif.done), 'h1);
        check("bad_eq_err", 32'(bif.err), 1);
        check("bad_eq_oe", 32'(bif.oe), 0);
        bif.dst = {3'd0, 3'd5};
        tick();
        check("bad_dst_grant", 32'(bif.grant), 'h1);
        tick();
        check("bad_dst_done", 32'(bif.done), 'h1);
        check("bad_dst_err", 32'(bif.err), 1);
        check("bad_dst_load", 32'(bif.load), 0);
        bif.src = {3'd0, 3'd6}; bif.dst = {3'd0, 3'd1};
        tick();
        check("bad_src_grant", 32'(bif.grant), 'h1);
        tick();
        check("bad_src_done", 32'(bif.done), 'h1);
        check("bad_src_err", 32'(bif.err), 1);
        bif.req = 2'b00;
        tick();
        check("bad_idle_grant", 32'(bif.grant), 0);
        for (int i = 0; i < NREG; i++) check("bad_bank", 32'(bank[i]), 32'h1111 * (i + 1));

        // reset during LOAD of a 0 -> 1 move
        preload(16'hAAAA, 16'h0000, 16'h3333, 16'h4444, 16'h5555);
        bif.src = {3'd0, 3'd0}; bif.dst = {3'd0, 3'd1}; bif.req = 2'b01;
        tick();
        check("rst_mid_grant", 32'(bif.grant), 'h1);
        tick(); tick();
        check("rst_mid_oe_pre", 32'(bif.oe), 'h1);
        check("rst_mid_load_pre", 32'(bif.load), 'h2);
        #2 reset = 1'b0;
        #1;
        check("rst_mid_oe", 32'(bif.oe), 0);
        check("rst_mid_load", 32'(bif.load), 0);
        check("rst_mid_busy", 32'(bif.busy), 0);
        bif.req = 2'b00;
        tick();
        check("rst_mid_no_done", 32'(bif.done), 0);
        reset = 1'b1;
        tick();
        check("rst_mid_reg1", 32'(bank[1]), 0);
        bif.src = {3'd4, 3'd2}; bif.dst = {3'd0, 3'd3}; bif.req = 2'b11;
        tick();
        check("rst_after_grant", 32'(bif.grant), 'h1);
        tick(); tick(); tick();
        check("rst_after_done", 32'(bif.done), 'h1);
        bif.req = 2'b00;
        tick();
        check("rst_after_idle", 32'(bif.grant), 0);

        // random sweep against a cycle model of the transfer timing
        reset = 1'b0; tick(); reset = 1'b1;
        m_ptr = 0; m_act = 1'b0; m_id = 0; m_age = 0; m_lat = 0;
        m_err = 1'b0; m_src = '0; m_dst = '0; n_grant = 0; n_done = 0;
        for (int c = 0; c < 1008; c++) begin
            if (c < 1000) begin
                bif.req = 2'($urandom_range(0, 3));
                bif.src = {3'($urandom_range(0, 5)), 3'($urandom_range(0, 5))};
                bif.dst = {3'($urandom_range(0, 5)), 3'($urandom_range(0, 5))};
            end else begin
                bif.req = 2'b00;
            end
            tick();
            e_grant = 0;
            if (!m_act) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (!m_act && bif.req[(m_ptr + k) % NREQ]) begin
                        m_id  = (m_ptr + k) % NREQ;
                        m_act = 1'b1;
                    end
                end
                if (m_act) begin
                    m_src   = sel(bif.src, m_id);
                    m_dst   = sel(bif.dst, m_id);
                    m_err   = (m_src == m_dst) || (m_src >= 3'(NREG)) || (m_dst >= 3'(NREG));
                    m_lat   = m_err ? REJECT_CYCLES - 1 : XFER_CYCLES - 1;
                    m_age   = 0;
                    m_ptr   = (m_id + 1) % NREQ;
                    e_grant = 32'(1) << m_id;
                end
            end else begin
                m_age++;
            end
            e_oe   = (m_act && !m_err && (m_age == 1 || m_age == 2)) ? (32'(1) << m_src) : 0;
            e_load = (m_act && !m_err && m_age == 2) ? (32'(1) << m_dst) : 0;
            e_done = (m_act && m_age == m_lat && m_age != 0) ? (32'(1) << m_id) : 0;
            check("rnd_grant", 32'(bif.grant), e_grant);
            check("rnd_oe", 32'(bif.oe), e_oe);
            check("rnd_load", 32'(bif.load), e_load);
            check("rnd_done", 32'(bif.done), e_done);
            check("rnd_busy", 32'(bif.busy), 32'(m_act && m_age >= 1));
            if (e_done != 0) check("rnd_err", 32'(bif.err), 32'(m_err));
            if (bif.grant != '0) n_grant++;
            if (bif.done != '0)  n_done++;
            if (m_act && m_age == m_lat && m_age != 0) m_act = 1'b0;
        end
        check("rnd_grant_done_balance", 32'(n_done), 32'(n_grant));
        check("rnd_final_busy", 32'(bif.busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
